settings_seq: RTL and testbench

SETTINGS_SEQ -- requirements
Module: settings_seq

---
 rtl/settings_seq_if.sv | 31 +++
 rtl/settings_seq.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_settings_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/settings_seq_if.sv
// -----------------------------------------------------------------------------
// settings_seq_if
// Purpose : host register bus for settings_seq. Word addressed, with a single
//           cycle write strobe and a read strobe whose data returns one cycle
//           later together with readdatavalid.
// Signals : address[15:0]   host word address
//           writedata[31:0] host write data
//           write           write strobe
//           read            read strobe
//           readdata[31:0]  read data (valid while readdatavalid is high)
//           readdatavalid   one-cycle qualifier for readdata
// Modports: master (host side), slave (settings_seq side)
// -----------------------------------------------------------------------------
interface settings_seq_if;
  logic [15:0] address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, writedata, write, read,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, write, read,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/settings_seq.sv
// -----------------------------------------------------------------------------
// settings_seq
// Purpose : setpoint generator for NCH channels. In point mode the outputs
//           follow the host-written POINT registers. In table mode a small
//           sequencer (IDLE -> FETCH -> HOLD) steps through a per-channel
//           table, presenting one entry per step for max(DWELL,1) cycles.
// Ports   : clk        single clock, rising edge
//           rst        asynchronous assert, active-low reset
//           host       settings_seq_if.slave register bus
//           set_out    NCH setpoints of 2*WIDTH_SET bits each, ch0 in the LSBs
//           set_strobe one-cycle pulse on every set_out update
//           busy       table sequencer running
// Register map (word addresses):
//           0x0000 CTRL  bit0 mode(1=point) bit1 start bit2 stop bit3 loop
//           0x0001 STATUS bit0 busy bit1 addr_err(W1C) bit2 done(W1C)
//           0x0002 LEN   0x0003 DWELL   0x0004 IDX (read-only)
//           0x0100+c POINT[c]   0x8000+c*DEPTH+k TABLE[c][k]
// Option  : define SETTINGS_SEQ_TABLE_RDBK_EN to make TABLE readable by the
//           host through a dedicated RAM read port. Without it the TABLE
//           region reads as zero (still acknowledged, no addr_err).
// -----------------------------------------------------------------------------
module settings_seq #(
  parameter int WIDTH_SET = 16,
  parameter int NCH       = 3,
  parameter int DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  settings_seq_if.slave              host,
  output logic [NCH*2*WIDTH_SET-1:0] set_out,
  output logic                       set_strobe,
  output logic                       busy
);
  localparam int SW = 2 * WIDTH_SET;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t        r_state;
  logic          r_mode;
  logic          r_loop;
  logic          r_addr_err;
  logic          r_done;
  logic [LW-1:0] r_len;
  logic [SW-1:0] r_dwell;
  logic [SW-1:0] r_hold_cnt;
  logic [AW-1:0] r_idx;
  logic [SW-1:0] r_point [NCH];
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic [NCH-1:0] r_byp_vld;
  logic [SW-1:0] r_byp_data;

  // ---------------- address decode ----------------
  logic          w_wr;
  logic          w_rd;
  logic [31:0]   w_addr32;
  logic [31:0]   w_pt_off;
  logic [31:0]   w_tbl_off;
  logic [31:0]   w_tbl_ch;
  logic [AW-1:0] w_tbl_k;
  logic [SW-1:0] w_wdata_sw;
  logic          w_hit_ctrl, w_hit_status, w_hit_len, w_hit_dwell, w_hit_idx;
  logic          w_hit_pt, w_hit_tbl, w_mapped;

  // A simultaneous read is dropped in favour of the write.
  assign w_wr       = host.write;
  assign w_rd       = host.read & ~host.write;
  assign w_addr32   = {16'd0, host.address};
  assign w_pt_off   = w_addr32 - 32'h0000_0100;
  assign w_tbl_off  = {17'd0, host.address[14:0]};
  assign w_tbl_ch   = w_tbl_off >> AW;
  assign w_tbl_k    = host.address[AW-1:0];
  assign w_wdata_sw = host.writedata[SW-1:0];

  assign w_hit_ctrl   = (host.address == 16'h0000);
  assign w_hit_status = (host.address == 16'h0001);
  assign w_hit_len    = (host.address == 16'h0002);
  assign w_hit_dwell  = (host.address == 16'h0003);
  assign w_hit_idx    = (host.address == 16'h0004);
  assign w_hit_pt     = (w_addr32 >= 32'h0000_0100) && (w_pt_off < 32'(NCH));
  assign w_hit_tbl    = host.address[15] && (w_tbl_off < 32'(NCH * DEPTH));
  assign w_mapped     = w_hit_ctrl | w_hit_status | w_hit_len | w_hit_dwell |
                        w_hit_idx | w_hit_pt | w_hit_tbl;

  // ---------------- control events ----------------
  logic w_wr_ctrl, w_start, w_abort, w_pt_upd, w_last;

  assign w_wr_ctrl = w_wr & w_hit_ctrl;
  // Start is only honoured when the same write leaves mode at table and
  // stop is not also requested.
  assign w_start   = w_wr_ctrl & host.writedata[1] & ~host.writedata[2] &
                     ~host.writedata[0] & (r_len != '0);
  // Stop, or any write selecting point mode, ends a running sequence.
  assign w_abort   = w_wr_ctrl & (host.writedata[2] | host.writedata[0]);
  assign w_pt_upd  = (w_wr_ctrl & host.writedata[0] & ~r_mode) |
                     (w_wr & w_hit_pt & r_mode);
  // Compare with >= so a LEN shrunk below the current index still ends the run.
  assign w_last    = ({1'b0, r_idx} + LW'(1)) >= r_len;

  logic [AW-1:0] w_idx_next;
  always_comb begin
    w_idx_next = r_idx;
    if (!w_abort) begin
      if (w_start) begin
        w_idx_next = '0;
      end else if (r_state == HOLD && r_hold_cnt == '0) begin
        if (!w_last)     w_idx_next = r_idx + AW'(1);
        else if (r_loop) w_idx_next = '0;
      end
    end
  end

  // ---------------- per-channel storage ----------------
  logic [NCH-1:0]    w_tbl_we;
  logic [NCH*SW-1:0] w_point_packed;
  logic [NCH*SW-1:0] w_fetch_packed;
  logic [SW-1:0]     w_point_next [NCH];
`ifdef SETTINGS_SEQ_TABLE_RDBK_EN
  logic [NCH*SW-1:0] w_rdbk_all;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [SW-1:0] r_mem [DEPTH];
      logic [SW-1:0] r_tbl_q;
`ifdef SETTINGS_SEQ_TABLE_RDBK_EN
      logic [SW-1:0] r_rdbk_q;
`endif

      assign w_tbl_we[gi] = w_wr && w_hit_tbl && (w_tbl_ch == 32'(gi));
      assign w_point_next[gi] = (w_wr && w_hit_pt && (w_pt_off == 32'(gi))) ?
                                w_wdata_sw : r_point[gi];
      assign w_point_packed[gi*SW +: SW] = w_point_next[gi];

      // The sequencer port reads the entry the next FETCH will use, so the
      // word is waiting in r_tbl_q during FETCH.
      always_ff @(posedge clk) begin
        if (w_tbl_we[gi]) r_mem[w_tbl_k] <= w_wdata_sw;
        r_tbl_q <= r_mem[w_idx_next];
`ifdef SETTINGS_SEQ_TABLE_RDBK_EN
        r_rdbk_q <= r_mem[w_tbl_k];
`endif
      end

      // Host writes landing on the fetched entry on the read edge or during
      // FETCH itself are forwarded, so the new value is what gets fetched.
      assign w_fetch_packed[gi*SW +: SW] =
          (w_tbl_we[gi] && (w_tbl_k == r_idx)) ? w_wdata_sw :
          r_byp_vld[gi]                        ? r_byp_data : r_tbl_q;
`ifdef SETTINGS_SEQ_TABLE_RDBK_EN
      assign w_rdbk_all[gi*SW +: SW] = r_rdbk_q;
`endif
    end
  endgenerate

  // ---------------- register read mux ----------------
  logic [31:0] w_rd_mux;
  always_comb begin
    w_rd_mux = '0;
    if (w_hit_ctrl)   w_rd_mux = {28'd0, r_loop, 2'b00, r_mode};
    if (w_hit_status) w_rd_mux = {29'd0, r_done, r_addr_err, busy};
    if (w_hit_len)    w_rd_mux = 32'(r_len);
    if (w_hit_dwell)  w_rd_mux = 32'(r_dwell);
    if (w_hit_idx)    w_rd_mux = 32'(r_idx);
    if (w_hit_pt) begin
      for (int c = 0; c < NCH; c++) begin
        if (w_pt_off == 32'(c)) w_rd_mux = 32'(r_point[c]);
      end
    end
  end

  // ---------------- registers and sequencer ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      set_out    <= '0;
      set_strobe <= 1'b0;
      r_idx      <= '0;
      r_hold_cnt <= '0;
      r_mode     <= 1'b0;
      r_loop     <= 1'b0;
      r_addr_err <= 1'b0;
      r_done     <= 1'b0;
      r_len      <= LW'(DEPTH);
      r_dwell    <= SW'(1);
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_byp_vld  <= '0;
      r_byp_data <= '0;
      for (int c = 0; c < NCH; c++) r_point[c] <= '0;
    end else begin
      set_strobe <= 1'b0;
      r_rvalid   <= w_rd;
      if (w_rd) r_rdata <= w_rd_mux;

      if (w_wr_ctrl) begin
        r_mode <= host.writedata[0];
        r_loop <= host.writedata[3];
      end
      if (w_wr & w_hit_len) begin
        if (host.writedata > 32'(DEPTH)) r_len <= LW'(DEPTH);
        else                             r_len <= host.writedata[LW-1:0];
      end
      if (w_wr & w_hit_dwell) r_dwell <= w_wdata_sw;
      for (int c = 0; c < NCH; c++) r_point[c] <= w_point_next[c];

      if (w_wr & w_hit_status & host.writedata[1]) r_addr_err <= 1'b0;
      if (w_wr & w_hit_status & host.writedata[2]) r_done     <= 1'b0;
      if ((w_wr | w_rd) & ~w_mapped)               r_addr_err <= 1'b1;

      r_byp_vld  <= w_tbl_we & {NCH{w_tbl_k == w_idx_next}};
      r_byp_data <= w_wdata_sw;
      r_idx      <= w_idx_next;

      if (w_abort) begin
        r_state <= IDLE;
        busy    <= 1'b0;
      end else if (w_start) begin
        r_state <= FETCH;
        busy    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          FETCH: begin
            set_out    <= w_fetch_packed;
            set_strobe <= 1'b1;
            // HOLD spans max(DWELL,1) cycles, counting down to zero.
            r_hold_cnt <= (r_dwell == '0) ? '0 : r_dwell - SW'(1);
            r_state    <= HOLD;
          end
          HOLD: begin
            if (r_hold_cnt != '0) begin
              r_hold_cnt <= r_hold_cnt - SW'(1);
            end else if (w_last && !r_loop) begin
              r_state <= IDLE;
              busy    <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end
          default: r_state <= IDLE;
        endcase
      end

      // Point updates come last so a switch to point mode during FETCH
      // presents the POINT values rather than the table entry.
      if (w_pt_upd) begin
        set_out    <= w_point_packed;
        set_strobe <= 1'b1;
      end
    end
  end

  assign host.readdatavalid = r_rvalid;

`ifdef SETTINGS_SEQ_TABLE_RDBK_EN
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  logic          r_rd_tbl;
  logic [CW-1:0] r_rd_ch;
  logic [SW-1:0] w_rdbk_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_tbl <= 1'b0;
      r_rd_ch  <= '0;
    end else begin
      r_rd_tbl <= w_rd & w_hit_tbl;
      if (w_rd) r_rd_ch <= w_tbl_ch[CW-1:0];
    end
  end

  always_comb begin
    w_rdbk_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_rd_ch == CW'(c)) w_rdbk_word = w_rdbk_all[c*SW +: SW];
    end
  end

  // Table words come straight from the RAM output register.
  assign host.readdata = r_rd_tbl ? 32'(w_rdbk_word) : r_rdata;
`else
  assign host.readdata = r_rdata;
`endif

endmodule

// File: tb/tb_settings_seq.sv
// -----------------------------------------------------------------------------
// tb_settings_seq
// Purpose : directed self-checking bench for settings_seq with default
//           parameters (WIDTH_SET=16, NCH=3, DEPTH=256). Stimulus is driven on
//           the falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_settings_seq;
  localparam int WIDTH_SET = 16;
  localparam int NCH       = 3;
  localparam int DEPTH     = 256;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NCH*2*WIDTH_SET-1:0] set_out;
  logic                       set_strobe;
  logic                       busy;

  settings_seq_if bus ();

  settings_seq #(
    .WIDTH_SET(WIDTH_SET),
    .NCH      (NCH),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (bus.slave),
    .set_out   (set_out),
    .set_strobe(set_strobe),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_tbl0 [4] = '{32'd10, 32'd20, 32'd30, 32'd40};

`ifdef SETTINGS_SEQ_TABLE_RDBK_EN
  localparam logic [31:0] RDBK_EXP = 32'd30;
`else
  localparam logic [31:0] RDBK_EXP = 32'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clk);
    bus.read    = 1'b0;
    check({tag, " valid"}, 32'(bus.readdatavalid), 32'd1);
    check(tag, bus.readdata, exp);
  endtask

  // Called on the falling edge of cycle T+1 after a start write at cycle T.
  // Strobes land at T+2+m*(dw+1); ch0 gets TABLE[0][m%4], ch1 100+(m%4).
  task automatic run_track(input string tag, input int ncyc, input int dw,
                           input bit lp, input logic [31:0] init);
    logic [31:0] ev;
    int          per;
    int          m;
    bit          st;
    bit          bz;
    per = dw + 1;
    ev  = init;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (cyc > 1) @(negedge clk);
      st = 1'b0;
      m  = 0;
      if (cyc >= 2 && ((cyc - 2) % per) == 0) begin
        m = (cyc - 2) / per;
        if (lp || m < 4) begin
          st = 1'b1;
          ev = exp_tbl0[m % 4];
        end
      end
      bz = lp || (cyc <= 4 * per);
      check($sformatf("%s T+%0d strobe", tag, cyc), 32'(set_strobe), 32'(st));
      check($sformatf("%s T+%0d busy", tag, cyc), 32'(busy), 32'(bz));
      check($sformatf("%s T+%0d ch0", tag, cyc), set_out[31:0], ev);
      if (st) check($sformatf("%s T+%0d ch1", tag, cyc), set_out[63:32], 32'(100 + (m % 4)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address   = '0;
    bus.writedata = '0;
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    rst           = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst strobe", 32'(set_strobe), 32'd0);
    check("rst rvalid", 32'(bus.readdatavalid), 32'd0);
    check("rst readdata", bus.readdata, 32'd0);
    check("rst ch0", set_out[31:0], 32'd0);
    check("rst ch2", set_out[95:64], 32'd0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("release strobe", 32'(set_strobe), 32'd0);
    end
    rd_chk("CTRL init", 16'h0000, 32'd0);
    rd_chk("STATUS init", 16'h0001, 32'd0);
    rd_chk("LEN init", 16'h0002, 32'd256);
    rd_chk("DWELL init", 16'h0003, 32'd1);
    rd_chk("IDX init", 16'h0004, 32'd0);

    // Point mode
    wr(16'h0000, 32'h1);
    check("to point strobe", 32'(set_strobe), 32'd1);
    check("to point ch1", set_out[63:32], 32'd0);
    wr(16'h0101, 32'h1234_5678);
    check("point1 strobe", 32'(set_strobe), 32'd1);
    check("point1 ch1", set_out[63:32], 32'h1234_5678);
    check("point1 ch0", set_out[31:0], 32'd0);
    @(negedge clk);
    check("point1 strobe off", 32'(set_strobe), 32'd0);
    rd_chk("POINT1 rd", 16'h0101, 32'h1234_5678);
    rd_chk("CTRL point", 16'h0000, 32'd1);

    // Table load, LEN saturation
    for (int k = 0; k < 4; k++) begin
      wr(16'h8000 + 16'(k), exp_tbl0[k]);
      wr(16'h8100 + 16'(k), 32'(100 + k));
    end
    rd_chk("TABLE rd", 16'h8002, RDBK_EXP);
    rd_chk("STATUS after tbl rd", 16'h0001, 32'd0);
    wr(16'h0002, 32'd300);
    rd_chk("LEN sat", 16'h0002, 32'd256);
    wr(16'h0002, 32'd4);
    wr(16'h0003, 32'd2);

    // Single pass
    wr(16'h0000, 32'h2);
    run_track("run", 14, 2, 1'b0, 32'd0);
    rd_chk("STATUS done", 16'h0001, 32'h4);
    rd_chk("IDX done", 16'h0004, 32'd3);
    wr(16'h0001, 32'h4);
    rd_chk("STATUS clr done", 16'h0001, 32'd0);

    // Looping, then stop
    wr(16'h0000, 32'hA);
    run_track("loop", 17, 2, 1'b1, 32'd40);
    wr(16'h0000, 32'hC);
    check("stop busy", 32'(busy), 32'd0);
    check("stop strobe", 32'(set_strobe), 32'd0);
    check("stop ch0", set_out[31:0], 32'd20);
    @(negedge clk);
    check("stop held strobe", 32'(set_strobe), 32'd0);
    check("stop held ch0", set_out[31:0], 32'd20);

    // Unmapped read, addr_err W1C
    rd_chk("unmapped rd", 16'h0050, 32'd0);
    @(negedge clk);
    check("unmapped rvalid off", 32'(bus.readdatavalid), 32'd0);
    rd_chk("STATUS addr_err", 16'h0001, 32'h2);
    wr(16'h0001, 32'h2);
    rd_chk("STATUS clr err", 16'h0001, 32'd0);

    // Simultaneous read and write: write only
    @(negedge clk);
    bus.address   = 16'h0003;
    bus.writedata = 32'd5;
    bus.write     = 1'b1;
    bus.read      = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    bus.read  = 1'b0;
    check("rw no rvalid", 32'(bus.readdatavalid), 32'd0);
    rd_chk("DWELL rw", 16'h0003, 32'd5);
    wr(16'h0003, 32'd2);

    // Start with LEN=0 ignored
    wr(16'h0002, 32'd0);
    wr(16'h0000, 32'h2);
    check("len0 busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("len0 strobe", 32'(set_strobe), 32'd0);
    wr(16'h0002, 32'd4);

    // Reset during HOLD of IDX=2
    wr(16'h0000, 32'h2);
    run_track("pre-rst", 8, 2, 1'b0, 32'd20);
    rst = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ch0", set_out[31:0], 32'd0);
    check("midrst ch1", set_out[63:32], 32'd0);
    check("midrst strobe", 32'(set_strobe), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post-rst strobe", 32'(set_strobe), 32'd0);
    rd_chk("IDX post-rst", 16'h0004, 32'd0);
    rd_chk("POINT1 post-rst", 16'h0101, 32'd0);
    rd_chk("DWELL post-rst", 16'h0003, 32'd1);
    wr(16'h0002, 32'd4);
    wr(16'h0000, 32'h2);
    run_track("rerun", 8, 1, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
